// File: rtl/score_text_gen.sv
// HUD text source: double-dabble score conversion and character-cell
// lookup feeding the font ROM.
module score_text_gen #(
   parameter int SCORE_W   = 14,
   parameter int SCORE_MAX = 9999
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [SCORE_W-1:0] score_in,
   input  logic               score_valid,
   input  logic [1:0]         lives,
   input  logic [7:0]         char_xy,
   output logic [6:0]         char_code,
   output logic               busy
);

   localparam int CW = $clog2(SCORE_W + 1);
   localparam int SW = SCORE_W + 16;
   localparam logic [SCORE_W-1:0] MAX_V = SCORE_W'(SCORE_MAX);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t             state, state_nx;
   logic [SW-1:0]      sreg, sreg_nx, adj;
   logic [CW-1:0]      cnt, cnt_nx;
   logic               pend, pend_nx;
   logic [SCORE_W-1:0] pend_val, pend_val_nx;
   logic [SCORE_W-1:0] src, clamped;
   logic [15:0]        digits, digits_nx;
   logic [6:0]         code_nx;
   logic [3:0]         row, col;
   logic [3:0]         nib;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         sreg      <= '0;
         cnt       <= '0;
         pend      <= 1'b0;
         pend_val  <= '0;
         digits    <= '0;
         char_code <= 7'h20;
      end else begin
         state     <= state_nx;
         sreg      <= sreg_nx;
         cnt       <= cnt_nx;
         pend      <= pend_nx;
         pend_val  <= pend_val_nx;
         digits    <= digits_nx;
         char_code <= code_nx;
      end
   end

   // A fresh request in IDLE is newer than anything pending.
   always_comb begin
      src     = score_valid ? score_in : pend_val;
      clamped = (src > MAX_V) ? MAX_V : src;
   end

   always_comb begin
      adj = sreg;
      for (int i = 0; i < 4; i++) begin
         if (sreg[SCORE_W+4*i +: 4] >= 4'd5)
            adj[SCORE_W+4*i +: 4] = sreg[SCORE_W+4*i +: 4] + 4'd3;
      end
   end

   always_comb begin
      state_nx    = state;
      sreg_nx     = sreg;
      cnt_nx      = cnt;
      pend_nx     = pend;
      pend_val_nx = pend_val;
      digits_nx   = digits;
      case (state)
         IDLE: begin
            if (score_valid || pend) begin
               sreg_nx  = {16'd0, clamped};
               pend_nx  = 1'b0;
               cnt_nx   = '0;
               state_nx = SHIFT;
            end
         end
         SHIFT: begin
            sreg_nx = {adj[SW-2:0], 1'b0};
            cnt_nx  = cnt + CW'(1);
            if (cnt == CW'(SCORE_W - 1))
               state_nx = DONE;
         end
         DONE: begin
            digits_nx = sreg[SW-1:SCORE_W];
            state_nx  = IDLE;
         end
         default: state_nx = IDLE;
      endcase
      if (score_valid && state != IDLE) begin
         pend_nx     = 1'b1;
         pend_val_nx = score_in;
      end
   end

   assign busy = (state != IDLE) || pend;

   assign row = char_xy[7:4];
   assign col = char_xy[3:0];

   always_comb begin
      nib = 4'd0;
      case (col)
         4'd6:    nib = digits[15:12];
         4'd7:    nib = digits[11:8];
         4'd8:    nib = digits[7:4];
         4'd9:    nib = digits[3:0];
         default: nib = 4'd0;
      endcase
   end

   always_comb begin
      code_nx = 7'h20;
      if (row == 4'd0) begin
         case (col)
            4'd0:    code_nx = 7'h53;
            4'd1:    code_nx = 7'h43;
            4'd2:    code_nx = 7'h4f;
            4'd3:    code_nx = 7'h52;
            4'd4:    code_nx = 7'h45;
            4'd6, 4'd7, 4'd8, 4'd9:
                     code_nx = 7'h30 + {3'b000, nib};
            default: code_nx = 7'h20;
         endcase
      end else if (row == 4'd1) begin
         case (col)
            4'd0:    code_nx = 7'h4c;
            4'd1:    code_nx = 7'h49;
            4'd2:    code_nx = 7'h56;
            4'd3:    code_nx = 7'h45;
            4'd4:    code_nx = 7'h53;
            default: begin
               if (col >= 4'd6 &&
                   {1'b0, col} < 5'd6 + {3'b000, lives})
                  code_nx = 7'h03;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_score_text_gen.sv
// Self-checking bench for score_text_gen: lookup scoreboard plus
// conversion timing, saturation, back-to-back and reset checks.
module tb_score_text_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic [13:0] score_in;
   logic        score_valid;
   logic [1:0]  lives;
   logic [7:0]  char_xy;
   logic [6:0]  char_code;
   logic        busy;

   int n_cmp = 0;
   int n_bad = 0;
   logic [6:0] exp_q[$];

   score_text_gen #(.SCORE_W(14), .SCORE_MAX(9999)) dut (
      .clk(clk), .rst(rst), .score_in(score_in),
      .score_valid(score_valid), .lives(lives), .char_xy(char_xy),
      .char_code(char_code), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h", tag, got, exp);
      end
   endtask

   task automatic lookup(input logic [7:0] xy, input logic [6:0] exp);
      logic [6:0] e;
      @(negedge clk);
      char_xy = xy;
      exp_q.push_back(exp);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk($sformatf("cell_%02h", xy), char_code, e);
   endtask

   task automatic convert(input logic [13:0] v);
      int n;
      @(negedge clk);
      score_in    = v;
      score_valid = 1'b1;
      @(negedge clk);
      score_valid = 1'b0;
      n = 0;
      while (busy && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("conv_timeout", n < 40, 1);
   endtask

   task automatic digits(input logic [6:0] d0, input logic [6:0] d1,
                         input logic [6:0] d2, input logic [6:0] d3);
      lookup(8'h06, d0);
      lookup(8'h07, d1);
      lookup(8'h08, d2);
      lookup(8'h09, d3);
   endtask

   initial begin
      int n;
      int first5, first7, saw4;
      rst = 1'b1; score_in = '0; score_valid = 1'b0;
      lives = 2'd0; char_xy = 8'h06;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_code", char_code, 7'h20);
      chk("rst_busy", busy, 0);
      @(negedge clk);
      rst = 1'b0;
      lookup(8'h06, 7'h30);
      lookup(8'h00, 7'h53);
      chk("idle_busy", busy, 0);

      // 1234: busy exactly 15 cycles, no early digit change
      @(negedge clk);
      char_xy = 8'h06; score_in = 14'd1234; score_valid = 1'b1;
      @(posedge clk);
      #1;
      score_valid = 1'b0;
      n = 0;
      while (busy && n < 40) begin
         chk("no_early", char_code, 7'h30);
         @(posedge clk);
         #1;
         n++;
      end
      chk("busy_len", n, 15);
      digits(7'h31, 7'h32, 7'h33, 7'h34);

      convert(14'd12000);
      digits(7'h39, 7'h39, 7'h39, 7'h39);
      convert(14'd0);
      digits(7'h30, 7'h30, 7'h30, 7'h30);

      // back-to-back: 555, then 42 and 77 queued; 77 wins
      first5 = -1; first7 = -1; saw4 = 0;
      @(negedge clk);
      char_xy = 8'h08; score_in = 14'd555; score_valid = 1'b1;
      @(posedge clk);
      for (int e = 1; e <= 40; e++) begin
         @(negedge clk);
         score_valid = (e == 5) || (e == 7);
         score_in    = (e == 5) ? 14'd42 : 14'd77;
         @(posedge clk);
         #1;
         if (char_code == 7'h35 && first5 < 0) first5 = e;
         if (char_code == 7'h37 && first7 < 0) first7 = e;
         if (char_code == 7'h34) saw4 = 1;
         if (e == 16) chk("b2b_busy_pend", busy, 1);
      end
      chk("b2b_first555", first5, 16);
      chk("b2b_first77", first7, 32);
      chk("b2b_no42", saw4, 0);
      chk("b2b_idle", busy, 0);
      digits(7'h30, 7'h30, 7'h37, 7'h37);

      // lives and blank cells
      lives = 2'd2;
      lookup(8'h16, 7'h03);
      lookup(8'h17, 7'h03);
      lookup(8'h18, 7'h20);
      lives = 2'd0;
      lookup(8'h16, 7'h20);
      lives = 2'd3;
      lookup(8'h18, 7'h03);
      lookup(8'h19, 7'h20);
      lookup(8'h35, 7'h20);
      lookup(8'h10, 7'h4c);
      lookup(8'h14, 7'h53);
      lookup(8'h05, 7'h20);
      lookup(8'h04, 7'h45);

      // reset during a 9876 conversion
      @(negedge clk);
      char_xy = 8'h06; score_in = 14'd9876; score_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      score_valid = 1'b0;
      repeat (6) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_code", char_code, 7'h20);
      @(negedge clk);
      rst = 1'b0;
      n = 0;
      repeat (20) begin
         @(posedge clk);
         #1;
         if (busy) n++;
      end
      chk("midrst_stay_idle", n, 0);
      digits(7'h30, 7'h30, 7'h30, 7'h30);

      chk("sb_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
